// File: rtl/tex_column_walker.sv
// rtl/tex_column_walker.sv - per-column row walker feeding the texture stage and the framebuffer
// Optional macro TEX_TIMEOUT_EN: abandon a texture request after TEX_TIMEOUT wait cycles.
`timescale 1ns/1ps

module tex_column_walker #(
   parameter int         SCREEN_WIDTH  = 320,
   parameter int         SCREEN_HEIGHT = 180,
   parameter logic [7:0] CEIL_COLOR    = 8'h11,
   parameter logic [7:0] FLOOR_COLOR   = 8'h22,
   parameter logic [7:0] FLAT_COLOR    = 8'hFF,
   parameter int         TEX_TIMEOUT   = 64
) (
   input  logic        pixel_clk_in,
   input  logic        rst_in,
   input  logic        col_valid_in,
   output logic        col_ready_out,
   input  logic [8:0]  hcount_ray_in,
   input  logic [7:0]  lineheight_in,
   input  logic [9:0]  drawstart_in,
   input  logic [15:0] wallX_in,
   input  logic [3:0]  texture_in,
   output logic        tex_req_out,
   output logic [15:0] tex_wallX_out,
   output logic [7:0]  tex_lineheight_out,
   output logic [9:0]  tex_drawstart_out,
   output logic [7:0]  tex_vcount_out,
   output logic [3:0]  tex_id_out,
   input  logic [7:0]  tex_pixel_in,
   input  logic        tex_valid_in,
   output logic        fb_we_out,
   output logic [15:0] fb_addr_out,
   output logic [7:0]  fb_data_out,
   output logic        col_done_out
);

   typedef enum logic [1:0] {S_IDLE, S_ROW, S_TEX_WAIT, S_DONE} state_t;

   state_t      state_q;
   logic [7:0]  row_q;
   logic [8:0]  hcount_q;

   logic [7:0]  row_d;
   logic [10:0] row_ext, wall_end_raw, wall_end;
   logic        above, is_wall, textured, in_range, last_row;
   logic [15:0] addr_d;
   logic [7:0]  span_pixel;

`ifdef TEX_TIMEOUT_EN
   logic [15:0] tmo_q;
`else
   logic        unused_tmo;
   assign unused_tmo = ^TEX_TIMEOUT;
`endif

   always_comb begin
      row_ext      = {3'b0, row_q};
      // 11-bit sum cannot overflow; clip so the wall never runs past the last row
      wall_end_raw = {1'b0, tex_drawstart_out} + {3'b0, tex_lineheight_out};
      wall_end     = (wall_end_raw > 11'(SCREEN_HEIGHT)) ? 11'(SCREEN_HEIGHT) : wall_end_raw;
      above        = row_ext < {1'b0, tex_drawstart_out};
      is_wall      = !above && (row_ext < wall_end);
      textured     = (tex_id_out >= 4'd2) && (tex_id_out <= 4'd9);
      in_range     = {1'b0, hcount_q} < 10'(SCREEN_WIDTH);
      last_row     = row_q == 8'(SCREEN_HEIGHT - 1);
      row_d        = row_q + 8'd1;
      addr_d       = 16'(row_q) * 16'(SCREEN_WIDTH) + 16'(hcount_q);
      span_pixel   = is_wall ? FLAT_COLOR : (above ? CEIL_COLOR : FLOOR_COLOR);
   end

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         state_q            <= S_IDLE;
         row_q              <= '0;
         hcount_q           <= '0;
         col_ready_out      <= 1'b1;
         tex_req_out        <= 1'b0;
         tex_wallX_out      <= '0;
         tex_lineheight_out <= '0;
         tex_drawstart_out  <= '0;
         tex_vcount_out     <= '0;
         tex_id_out         <= '0;
         fb_we_out          <= 1'b0;
         fb_addr_out        <= '0;
         fb_data_out        <= '0;
         col_done_out       <= 1'b0;
`ifdef TEX_TIMEOUT_EN
         tmo_q              <= '0;
`endif
      end else begin
         fb_we_out    <= 1'b0;
         col_done_out <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (col_valid_in) begin
                  hcount_q           <= hcount_ray_in;
                  tex_wallX_out      <= wallX_in;
                  tex_lineheight_out <= lineheight_in;
                  tex_drawstart_out  <= drawstart_in;
                  tex_id_out         <= texture_in;
                  row_q              <= '0;
                  col_ready_out      <= 1'b0;
                  state_q            <= S_ROW;
               end
            end
            S_ROW: begin
               if (is_wall && textured && in_range) begin
                  tex_vcount_out <= row_q;
                  tex_req_out    <= 1'b1;
                  state_q        <= S_TEX_WAIT;
`ifdef TEX_TIMEOUT_EN
                  tmo_q          <= '0;
`endif
               end else begin
                  // out-of-range columns still walk every row, silently
                  if (in_range) begin
                     fb_we_out   <= 1'b1;
                     fb_addr_out <= addr_d;
                     fb_data_out <= span_pixel;
                  end
                  if (last_row) begin
                     state_q <= S_DONE;
                  end else begin
                     row_q <= row_d;
                  end
               end
            end
            S_TEX_WAIT: begin
               if (tex_valid_in) begin
                  fb_we_out   <= 1'b1;
                  fb_addr_out <= addr_d;
                  fb_data_out <= tex_pixel_in;
                  tex_req_out <= 1'b0;
                  state_q     <= last_row ? S_DONE : S_ROW;
                  if (!last_row) row_q <= row_d;
               end
`ifdef TEX_TIMEOUT_EN
               else if (tmo_q == 16'(TEX_TIMEOUT - 1)) begin
                  fb_we_out   <= 1'b1;
                  fb_addr_out <= addr_d;
                  fb_data_out <= FLAT_COLOR;
                  tex_req_out <= 1'b0;
                  state_q     <= last_row ? S_DONE : S_ROW;
                  if (!last_row) row_q <= row_d;
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
`endif
            end
            S_DONE: begin
               col_done_out  <= 1'b1;
               col_ready_out <= 1'b1;
               row_q         <= '0;
               state_q       <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tex_column_walker.sv
// tb/tb_tex_column_walker.sv - directed and randomized bench for tex_column_walker
// Builds with or without TEX_TIMEOUT_EN; expectations switch with the macro.
`timescale 1ns/1ps

module tb_tex_column_walker;
   localparam int W = 320;
   localparam int H = 180;
   localparam logic [7:0] CEIL  = 8'h11;
   localparam logic [7:0] FLOOR = 8'h22;
   localparam logic [7:0] FLAT  = 8'hFF;

   logic        clk = 1'b0, rst = 1'b1;
   logic        col_valid_in = 1'b0, col_ready_out;
   logic [8:0]  hcount_ray_in = '0;
   logic [7:0]  lineheight_in = '0;
   logic [9:0]  drawstart_in = '0;
   logic [15:0] wallX_in = '0;
   logic [3:0]  texture_in = '0;
   logic        tex_req_out;
   logic [15:0] tex_wallX_out;
   logic [7:0]  tex_lineheight_out, tex_vcount_out;
   logic [9:0]  tex_drawstart_out;
   logic [3:0]  tex_id_out;
   logic [7:0]  tex_pixel_in;
   logic        tex_valid_in;
   logic        fb_we_out, col_done_out;
   logic [15:0] fb_addr_out;
   logic [7:0]  fb_data_out;

   tex_column_walker #(.TEX_TIMEOUT(8)) dut (
      .pixel_clk_in(clk), .rst_in(rst),
      .col_valid_in(col_valid_in), .col_ready_out(col_ready_out),
      .hcount_ray_in(hcount_ray_in), .lineheight_in(lineheight_in),
      .drawstart_in(drawstart_in), .wallX_in(wallX_in), .texture_in(texture_in),
      .tex_req_out(tex_req_out), .tex_wallX_out(tex_wallX_out),
      .tex_lineheight_out(tex_lineheight_out), .tex_drawstart_out(tex_drawstart_out),
      .tex_vcount_out(tex_vcount_out), .tex_id_out(tex_id_out),
      .tex_pixel_in(tex_pixel_in), .tex_valid_in(tex_valid_in),
      .fb_we_out(fb_we_out), .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out),
      .col_done_out(col_done_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0;
   int cyc = 0, done_cnt = 0, done_cyc = 0, desc_err = 0;
   logic [23:0] wr_q[$];
   int          wr_cyc_q[$];
   int          req_cyc_q[$];
   logic [23:0] exp_q[$];
   logic [37:0] exp_desc = '0;
   logic        req_prev = 1'b0;

   // texture stage model: answers pixel = requested row, two cycles after the request edge
   int          tex_mode = 0, tm_cnt = 0;
   logic        tm_valid = 1'b0, tm_req_prev = 1'b0, tb_valid = 1'b0;
   logic [7:0]  tm_pixel = '0;
   assign tex_valid_in = tm_valid | tb_valid;
   assign tex_pixel_in = tm_pixel;

   always @(negedge clk) begin
      tm_valid = 1'b0;
      if (tm_cnt == 1) begin
         tm_valid = 1'b1;
         tm_pixel = tex_vcount_out;
         tm_cnt   = 0;
      end
      if (tex_mode != 0 && tex_req_out && !tm_req_prev) tm_cnt = 1;
      tm_req_prev = tex_req_out;
   end

   always @(negedge clk) begin
      cyc++;
      if (fb_we_out) begin
         wr_q.push_back({fb_addr_out, fb_data_out});
         wr_cyc_q.push_back(cyc);
      end
      if (tex_req_out && !req_prev) req_cyc_q.push_back(cyc);
      req_prev = tex_req_out;
      if (col_done_out) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (!col_ready_out &&
          {tex_id_out, tex_wallX_out, tex_lineheight_out, tex_drawstart_out} !== exp_desc)
         desc_err++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [79:0] out_vec();
      return 80'({col_ready_out, tex_req_out, tex_wallX_out, tex_lineheight_out,
                  tex_drawstart_out, tex_vcount_out, tex_id_out, fb_we_out,
                  fb_addr_out, fb_data_out, col_done_out});
   endfunction

   localparam logic [79:0] RESET_VEC = 80'(1) << 73;

   // Expected framebuffer stream for one column, straight from the row rules
   function automatic int build_exp(input int col, input int ds, input int lh,
                                    input int tex, input bit flat_tex);
      int nreq = 0;
      int wend = ds + lh;
      logic [7:0] d;
      exp_q.delete();
      if (wend > H) wend = H;
      if (col < W) begin
         for (int r = 0; r < H; r++) begin
            if (r < ds) d = CEIL;
            else if (r < wend) begin
               if (tex >= 2 && tex <= 9) begin
                  nreq++;
                  d = flat_tex ? FLAT : 8'(r);
               end else d = FLAT;
            end else d = FLOOR;
            exp_q.push_back({16'(r * W + col), d});
         end
      end
      return nreq;
   endfunction

   task automatic clear_mon();
      wr_q.delete();
      wr_cyc_q.delete();
      req_cyc_q.delete();
      done_cnt = 0;
      desc_err = 0;
   endtask

   task automatic set_desc(input int col, input int ds, input int lh, input int tex,
                           input logic [15:0] wx);
      hcount_ray_in = 9'(col);
      drawstart_in  = 10'(ds);
      lineheight_in = 8'(lh);
      texture_in    = 4'(tex);
      wallX_in      = wx;
      exp_desc      = {4'(tex), wx, 8'(lh), 10'(ds)};
   endtask

   task automatic start_col(input int col, input int ds, input int lh, input int tex,
                            input logic [15:0] wx);
      set_desc(col, ds, lh, tex, wx);
      clear_mon();
      col_valid_in = 1'b1;
      tick();
      col_valid_in = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 4000 && done_cnt < target; i++) tick();
   endtask

   task automatic check_col(input string tag, input int col, input int ds, input int lh,
                            input int tex, input bit flat_tex);
      int nreq;
      int n;
      nreq = build_exp(col, ds, lh, tex, flat_tex);
      wait_done(1);
      repeat (2) tick();
      chk($sformatf("%s done_count", tag), 80'(done_cnt), 80'(1));
      chk($sformatf("%s write_count", tag), 80'(wr_q.size()), 80'(exp_q.size()));
      n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s row%0d addr_data", tag, i), 80'(wr_q[i]), 80'(exp_q[i]));
      chk($sformatf("%s req_count", tag), 80'(req_cyc_q.size()), 80'(nreq));
      chk($sformatf("%s desc_stable", tag), 80'(desc_err), 80'(0));
      chk($sformatf("%s ready_after", tag), 80'(col_ready_out), 80'(1));
      if (exp_q.size() > 0 && wr_cyc_q.size() > 0)
         chk($sformatf("%s done_latency", tag), 80'(done_cyc - wr_cyc_q[$]), 80'(1));
   endtask

   initial begin
      int col, ds, lh, tex;

      repeat (3) tick();
      chk("reset_outputs", out_vec(), RESET_VEC);
      rst = 1'b0;
      tick();

      // mid-column reset while a request is outstanding
      tex_mode = 0;
      start_col(3, 0, 100, 5, 16'hBEEF);
      repeat (4) tick();
      chk("midcol_req_pending", 80'(tex_req_out), 80'(1));
      rst = 1'b1;
      tick();
      chk("midcol_reset_outputs", out_vec(), RESET_VEC);
      rst = 1'b0;
      clear_mon();
      tb_valid = 1'b1;
      tick();
      tb_valid = 1'b0;
      repeat (4) tick();
      chk("stray_valid_writes", 80'(wr_q.size()), 80'(0));
      chk("stray_valid_ready", 80'(col_ready_out), 80'(1));

      tex_mode = 1;
      start_col(10, 200, 0, 7, 16'h1234);
      check_col("ceil_only", 10, 200, 0, 7, 1'b0);

      start_col(0, 170, 20, 5, 16'h8001);
      check_col("clipped_tex", 0, 170, 20, 5, 1'b0);
      if (req_cyc_q.size() >= 2)
         chk("clipped_req_gap", 80'(req_cyc_q[1] - req_cyc_q[0] > 1), 80'(1));

      start_col(319, 50, 10, 1, 16'h00FF);
      check_col("flat_edge", 319, 50, 10, 1, 1'b0);
      if (wr_q.size() > 0)
         chk("flat_edge_last_addr", 80'(wr_q[$][23:8]), 80'(57599));

      // out-of-range column with col_valid held high across DONE
      set_desc(400, 20, 30, 5, 16'h4242);
      clear_mon();
      col_valid_in = 1'b1;
      wait_done(1);
      chk("oor_done_once", 80'(done_cnt), 80'(1));
      chk("oor_no_writes", 80'(wr_q.size()), 80'(0));
      chk("oor_no_reqs", 80'(req_cyc_q.size()), 80'(0));
      tick();
      chk("oor_reaccept", 80'(col_ready_out), 80'(0));
      col_valid_in = 1'b0;
      wait_done(2);
      chk("oor_second_done", 80'(done_cnt), 80'(2));
      chk("oor_second_no_writes", 80'(wr_q.size()), 80'(0));
      tick();

      for (int k = 0; k < 4; k++) begin
         col = int'($urandom_range(0, 340));
         ds  = int'($urandom_range(0, 190));
         lh  = int'($urandom_range(0, 255));
         tex = int'($urandom_range(0, 15));
         start_col(col, ds, lh, tex, 16'($urandom));
         check_col($sformatf("rand%0d", k), col, ds, lh, tex, 1'b0);
      end

      tex_mode = 0;
`ifdef TEX_TIMEOUT_EN
      start_col(7, 10, 3, 5, 16'h7777);
      check_col("timeout", 7, 10, 3, 5, 1'b1);
      if (wr_cyc_q.size() >= 13 && req_cyc_q.size() >= 3)
         for (int k = 0; k < 3; k++)
            chk($sformatf("timeout_latency%0d", k), 80'(wr_cyc_q[10 + k] - req_cyc_q[k]), 80'(8));
`else
      start_col(7, 10, 3, 5, 16'h7777);
      repeat (300) tick();
      chk("nto_writes", 80'(wr_q.size()), 80'(10));
      chk("nto_req_held", 80'(tex_req_out), 80'(1));
      chk("nto_no_done", 80'(done_cnt), 80'(0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("nto_reset_outputs", out_vec(), RESET_VEC);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
